// File: rtl/grant_decoder.sv
// grant_decoder: queued request FIFO feeding a one-hot grant FSM.
// Optional grant timeout is enabled by defining GRANT_TIMEOUT_EN.
module grant_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          valid,
  input  logic [2:0]                    selected,
  input  logic [7:0]                    ack,
  output logic                          ready,
  output logic [7:0]                    channels,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          push;
  logic          pop;
  logic [2:0]    head;

  state_t        state_q;
  logic [2:0]    idx_q;
  logic [7:0]    hold_q;
  logic [7:0]    hold_d;
  logic [7:0]    chan_q;
  logic          busy_q;
  logic          tmo_q;
  logic          tmo_hit;

  // A full queue never accepts, even when a pop frees a slot this cycle.
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign push = valid && !full;
  assign head = mem_q[rd_q];

  // The head leaves the queue whenever a new grant is issued.
  assign pop = (state_q != S_GRANT) && enable && (cnt_q != '0);

  // Counter parks at its last value instead of wrapping.
  assign hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 8'd1;

`ifdef GRANT_TIMEOUT_EN
  assign tmo_hit = (hold_q == HOLD_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign ready    = !full;
  assign pending  = cnt_q;
  assign channels = chan_q;
  assign busy     = busy_q;
  assign timeout  = tmo_q;

  // Queue storage; contents need no reset, the pointers guard them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= selected;
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Grant FSM with registered one-hot, busy and timeout outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      chan_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        S_GRANT: begin
          if (!enable) begin
            chan_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (ack[idx_q]) begin
            chan_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else if (tmo_hit) begin
            chan_q  <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= S_RELEASE;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: begin
          if (pop) begin
            idx_q   <= head;
            chan_q  <= 8'b1 << head;
            busy_q  <= 1'b1;
            hold_q  <= '0;
            state_q <= S_GRANT;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
